dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 64-bit doublewords stored.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (legal 1..7).
REQ-003 SHALL have port clk_div  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  the MEM stage presents a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  64  byte address from the ALU result.
REQ-008 SHALL have port req_wdata  input  64  store data.
REQ-009 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  output  64  load data, registered.
REQ-012 SHALL have port rsp_err  output  1  the request was misaligned or out of range.
REQ-013 SHALL have port stall  output  1  freezes the pipeline while a request is outstanding.

Function
REQ-014 SHALL implement the states IDLE, BUSY and RESP.
REQ-015 req_ready SHALL equal (state==IDLE).
REQ-016 Acceptance SHALL occur when req_valid && req_ready; it captures req_write, req_addr and req_wdata internally.
REQ-017 On acceptance the next state SHALL be RESP if LATENCY==1, else BUSY with the counter loaded to LATENCY-2.
REQ-018 In BUSY the counter SHALL decrement each cycle; at 0 the next state is RESP.
REQ-019 rsp_valid SHALL be high for exactly the cycle in RESP, which is LATENCY cycles after the acceptance edge; RESP always goes to IDLE.
REQ-020 A store SHALL commit to storage on the edge entering RESP, and SHALL NOT commit if rsp_err.
REQ-021 A load SHALL register storage[word index] into rsp_rdata on the edge entering RESP; rsp_rdata holds until the next response.
REQ-022 A store response SHALL leave rsp_rdata unchanged.
REQ-023 Word index SHALL be req_addr[$clog2(DEPTH)+2:3].
REQ-024 stall SHALL equal req_valid && !rsp_valid.
REQ-025 The requester holds req_* stable until rsp_valid and drops req_valid the cycle after; req_valid still high in the IDLE cycle after RESP SHALL count as a new request.
REQ-026 Back-to-back requests SHALL have a throughput of one per LATENCY+1 cycles.

Reset
REQ-027 While rst==0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, hence req_ready=1.
REQ-028 Reset mid-BUSY SHALL abort the request with no store committed and no response issued.
REQ-029 Storage contents SHALL NOT be reset.

Configuration
REQ-030 With DMEM_RESP_ERR_EN defined, rsp_err (registered with the response) SHALL be 1 when req_addr[2:0]!=0 or the upper address bits above the index are nonzero; an errored load SHALL return rsp_rdata=0.
REQ-031 With DMEM_RESP_ERR_EN undefined, rsp_err SHALL be tied 0, req_addr[2:0] SHALL be ignored, and the index SHALL wrap modulo DEPTH.

Structure
REQ-032 Package dmem_pkg SHALL hold DATA_W=64, ADDR_W=64, the state enum typedef and the counter width constant (3).
REQ-033 Storage SHALL be a sub-module dmem_array (synchronous write port, combinational read, DEPTH x 64).

Verification
REQ-034 LATENCY=2: store addr 0x10 data 0xDEADBEEF_CAFEF00D, then load 0x10 -> rsp_valid 2 cycles after each acceptance; load returns 0xDEADBEEF_CAFEF00D; stall high on both acceptance cycles and the following BUSY cycle.
REQ-035 LATENCY=1: load 0x8 -> rsp_valid on the cycle after acceptance; req_ready low in that cycle.
REQ-036 With DMEM_RESP_ERR_EN: store addr 0x13 -> rsp_err=1, and a subsequent load of 0x10 returns the prior value unchanged; load 0x800 with DEPTH=256 -> rsp_err=1, rsp_rdata=0.
REQ-037 Without DMEM_RESP_ERR_EN: store 0x55 to addr 0x808 with DEPTH=256, then load 0x8 -> 0x55.
REQ-038 rst pulsed low during BUSY of a store to 0x20 -> no rsp_valid, req_ready=1 next cycle, and a load of 0x20 returns the old contents.
REQ-039 req_valid held high through RESP with LATENCY=3 -> second acceptance exactly in the IDLE cycle after RESP; rsp_valid pulses 4 cycles apart.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder slice.
package dmem_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: synchronous write port, combinational read, never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the addressed doubleword when enabled; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// Optional feature macro: DMEM_RESP_ERR_EN enables misalignment/range errors;
// without it rsp_err is tied low and the word index wraps modulo DEPTH.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk_div,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept;
  logic              enter_resp;
  logic              op_write;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic              op_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept = req_valid && (state_q == IDLE);

  // A single-cycle latency enters RESP straight from IDLE, before the
  // captured copy exists, so the live request is used in that case.
  assign op_write = (state_q == IDLE) ? req_write : write_q;
  assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign op_idx   = op_addr[IDX_W+2:3];

`ifdef DMEM_RESP_ERR_EN
  assign op_err = (op_addr[2:0] != 3'b000) || (op_addr[ADDR_W-1:IDX_W+3] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{op_addr[2:0], op_addr[ADDR_W-1:IDX_W+3]};
  assign op_err = 1'b0;
`endif

  // Next-state logic: accept in IDLE, count down in BUSY, single RESP cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold the accepted request for the whole BUSY period.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Gating with rst keeps an aborted or reset-time request from writing.
  assign mem_we = rst && enter_resp && op_write && !op_err;

  dmem_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk_i  (clk_div),
    .we_i   (mem_we),
    .idx_i  (op_idx),
    .wdata_i(op_wdata),
    .rdata_o(mem_rdata)
  );

  // Load data is registered on the edge entering RESP; stores leave it alone.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      rsp_rdata_q <= '0;
    end else if (enter_resp && !op_write) begin
      rsp_rdata_q <= op_err ? '0 : mem_rdata;
    end
  end

`ifdef DMEM_RESP_ERR_EN
  logic rsp_err_q;

  // Error flag is registered alongside the response.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      rsp_err_q <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_q <= op_err;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign stall     = req_valid && !rsp_valid;

endmodule
